// File: rtl/tq_rec_wr_ctrl_pkg.sv
// Constants, block map and FSM encoding shared by the TQ/reconstruction RAM writer.
// Build option TQ_REC_TRANSPOSE_EN selects column-wise beats in tq_rec_pack4x4.
package tq_rec_wr_ctrl_pkg;

  localparam int PIX_W  = 8;
  localparam int ADDR_W = 5;
  localparam int ROW_W  = 4 * PIX_W;
  localparam int WORD_W = 16 * PIX_W;

  // Block map of one macroblock: 16 luma, then 4 Cb, then 4 Cr.
  localparam int LUMA_BASE = 0;
  localparam int CB_BASE   = LUMA_BASE + 16;
  localparam int CR_BASE   = CB_BASE + 4;
  localparam int BLK_NUM   = CR_BASE + 4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_FREE = 2'd1,
    ST_FILL      = 2'd2,
    ST_DONE      = 2'd3
  } wr_state_e;

  function automatic logic is_last_blk(input logic [ADDR_W-1:0] blk);
    return blk == ADDR_W'(BLK_NUM - 1);
  endfunction

endpackage

// File: rtl/tq_rec_pack4x4.sv
// Collects four beats of a 4x4 block into one row-major word.
// With TQ_REC_TRANSPOSE_EN each beat is a column and is scattered across rows.
module tq_rec_pack4x4
  import tq_rec_wr_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [1:0]        i_slot,
  input  logic [ROW_W-1:0]  i_beat,
  output logic [WORD_W-1:0] o_word
);

  logic [WORD_W-1:0] r_pack;

  // o_word already contains the beat being loaded, so the 4th beat can be
  // written out on the same edge that captures it.
  for (genvar gi = 0; gi < 16; gi++) begin : g_elem
    localparam int ROW = gi / 4;
    localparam int COL = gi % 4;
    logic             w_hit;
    logic [PIX_W-1:0] w_src;
`ifdef TQ_REC_TRANSPOSE_EN
    assign w_hit = i_load && (i_slot == 2'(COL));
    assign w_src = i_beat[ROW*PIX_W +: PIX_W];
`else
    assign w_hit = i_load && (i_slot == 2'(ROW));
    assign w_src = i_beat[COL*PIX_W +: PIX_W];
`endif
    assign o_word[gi*PIX_W +: PIX_W] = w_hit ? w_src : r_pack[gi*PIX_W +: PIX_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pack <= '0;
    end else if (i_load) begin
      r_pack <= o_word;
    end
  end

endmodule

// File: rtl/tq_rec_wr_ctrl.sv
// Writes one macroblock of reconstructed 4x4 blocks (24 words) into the TQ/rec RAM.
// Optional build macro: TQ_REC_TRANSPOSE_EN (column-wise input beats).
module tq_rec_wr_ctrl
  import tq_rec_wr_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              ram_free_i,
  input  logic              rec_val_i,
  input  logic [ROW_W-1:0]  rec_data_i,
  output logic              rec_rdy_o,
  output logic              we_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [WORD_W-1:0] wdata_o,
  output logic              busy_o,
  output logic              mb_done_o,
  output logic              ovf_o
);

  wr_state_e         r_state;
  wr_state_e         w_state_next;
  logic [1:0]        r_row_cnt;
  logic [ADDR_W-1:0] r_blk_cnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [WORD_W-1:0] r_wdata;
  logic              r_mb_done;
  logic              r_ovf;

  logic              w_rdy;
  logic              w_busy;
  logic              w_xfer;
  logic              w_blk_done;
  logic              w_mb_last;
  logic              w_start_mb;
  logic [WORD_W-1:0] w_word;

  assign w_xfer     = rec_val_i & w_rdy;
  assign w_blk_done = w_xfer & (r_row_cnt == 2'd3);
  assign w_mb_last  = w_blk_done & is_last_blk(r_blk_cnt);
  assign w_start_mb = (r_state == ST_IDLE) & start_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // WAIT_FREE always lasts at least one cycle, even if ram_free_i is already high.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:      if (start_i)    w_state_next = ST_WAIT_FREE;
      ST_WAIT_FREE: if (ram_free_i) w_state_next = ST_FILL;
      ST_FILL:      if (w_mb_last)  w_state_next = ST_DONE;
      ST_DONE:                      w_state_next = ST_IDLE;
      default:                      w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_rdy  = 1'b0;
    w_busy = 1'b1;
    case (r_state)
      ST_IDLE: w_busy = 1'b0;
      ST_FILL: w_rdy  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row_cnt <= 2'd0;
      r_blk_cnt <= '0;
    end else if (w_start_mb) begin
      r_row_cnt <= 2'd0;
      r_blk_cnt <= ADDR_W'(LUMA_BASE);
    end else if (w_xfer) begin
      r_row_cnt <= r_row_cnt + 2'd1;
      if (w_mb_last) begin
        r_blk_cnt <= ADDR_W'(LUMA_BASE);
      end else if (w_blk_done) begin
        r_blk_cnt <= r_blk_cnt + 1'b1;
      end
    end
  end

  // Write port and status flags; address and data hold between writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we      <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_mb_done <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_we      <= w_blk_done;
      r_mb_done <= (r_state == ST_DONE);
      if (w_blk_done) begin
        r_waddr <= r_blk_cnt;
        r_wdata <= w_word;
      end
      if (rec_val_i && !w_rdy) begin
        r_ovf <= 1'b1;
      end
    end
  end

  tq_rec_pack4x4 u_pack (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_xfer),
    .i_slot (r_row_cnt),
    .i_beat (rec_data_i),
    .o_word (w_word)
  );

  assign rec_rdy_o = w_rdy;
  assign busy_o    = w_busy;
  assign we_o      = r_we;
  assign waddr_o   = r_waddr;
  assign wdata_o   = r_wdata;
  assign mb_done_o = r_mb_done;
  assign ovf_o     = r_ovf;

endmodule

// File: tb/tb_tq_rec_wr_ctrl.sv
// Directed bench for tq_rec_wr_ctrl: control-sequence table plus full-macroblock runs.
module tb_tq_rec_wr_ctrl;

  logic         clk;
  logic         rst;
  logic         start_i;
  logic         ram_free_i;
  logic         rec_val_i;
  logic [31:0]  rec_data_i;
  logic         rec_rdy_o;
  logic         we_o;
  logic [4:0]   waddr_o;
  logic [127:0] wdata_o;
  logic         busy_o;
  logic         mb_done_o;
  logic         ovf_o;

  tq_rec_wr_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .ram_free_i (ram_free_i),
    .rec_val_i  (rec_val_i),
    .rec_data_i (rec_data_i),
    .rec_rdy_o  (rec_rdy_o),
    .we_o       (we_o),
    .waddr_o    (waddr_o),
    .wdata_o    (wdata_o),
    .busy_o     (busy_o),
    .mb_done_o  (mb_done_o),
    .ovf_o      (ovf_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Write monitor, sampled 1 time unit after each rising edge.
  int           cyc = 0;
  logic [4:0]   log_addr[$];
  logic [127:0] log_data[$];
  int           last_we_cyc = -1;
  int           done_cyc = -1;
  int           done_cnt = 0;
  int           back2back = 0;
  logic         prev_we = 1'b0;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (we_o) begin
      if (prev_we) back2back++;
      log_addr.push_back(waddr_o);
      log_data.push_back(wdata_o);
      last_we_cyc = cyc;
    end
    prev_we = we_o;
    if (mb_done_o) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    last_we_cyc = -1;
    done_cyc = -1;
    done_cnt = 0;
    back2back = 0;
  endtask

  function automatic logic [127:0] exp_word(input int b);
    logic [127:0] w;
    w = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
`ifdef TQ_REC_TRANSPOSE_EN
        w[(r*4+c)*8 +: 8] = 8'(4*b + c);
`else
        w[(r*4+c)*8 +: 8] = 8'(4*b + r);
`endif
      end
    end
    return w;
  endfunction

  task automatic start_mb();
    rec_val_i  = 1'b0;
    ram_free_i = 1'b1;
    start_i    = 1'b1;
    tick();
    start_i    = 1'b0;
  endtask

  task automatic wait_rdy(input string nm);
    for (int t = 0; t < 20; t++) begin
      if (rec_rdy_o) break;
      tick();
    end
    chk({nm, "_rdy"}, rec_rdy_o, 1'b1);
  endtask

  task automatic push_beat(input logic [31:0] d);
    bit ok;
    ok = 1'b0;
    rec_val_i  = 1'b1;
    rec_data_i = d;
    for (int t = 0; t < 50 && !ok; t++) begin
      if (rec_rdy_o) ok = 1'b1;
      tick();
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL beat_accept: got no rec_rdy_o required acceptance within 50 cycles");
    end
  endtask

  task automatic run_beats(input int n, input bit gaps, input int pulse_at);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      if (gaps && ($urandom_range(0, 1) == 1)) begin
        rec_val_i = 1'b0;
        tick();
      end
      b = i[7:0];
      start_i = (i == pulse_at);
      push_beat({4{b}});
      start_i = 1'b0;
    end
    rec_val_i = 1'b0;
    for (int t = 0; t < 4; t++) tick();
  endtask

  task automatic check_mb(input string nm);
    chk({nm, "_nwr"}, 128'(log_addr.size()), 128'd24);
    for (int i = 0; i < 24; i++) begin
      chk($sformatf("%s_addr%0d", nm, i), 128'(log_addr[i]), 128'(i));
      chk($sformatf("%s_data%0d", nm, i), log_data[i], exp_word(i));
    end
    chk({nm, "_ndone"}, 128'(done_cnt), 128'd1);
    chk({nm, "_done_lat"}, 128'(done_cyc), 128'(last_we_cyc + 1));
    chk({nm, "_b2b"}, 128'(back2back), 128'd0);
    chk({nm, "_idle"}, {busy_o, rec_rdy_o}, 2'b00);
  endtask

  typedef struct {
    logic rst;
    logic start;
    logic free;
    logic val;
    logic exp_rdy;
    logic exp_busy;
    logic exp_ovf;
  } vec_t;

  vec_t vt[21];

  initial begin
    rst = 1'b1; start_i = 1'b0; ram_free_i = 1'b0;
    rec_val_i = 1'b0; rec_data_i = '0;

    // {rst, start, free, val} -> outputs sampled after that cycle's edge
    vt[0]  = '{1,0,0,0, 0,0,0};
    vt[1]  = '{0,0,0,0, 0,0,0};
    vt[2]  = '{0,1,0,0, 0,1,0};
    vt[3]  = '{0,0,0,0, 0,1,0};
    vt[4]  = '{0,0,0,0, 0,1,0};
    vt[5]  = '{0,0,0,1, 0,1,1};
    vt[6]  = '{0,0,0,0, 0,1,1};
    vt[7]  = '{0,0,0,0, 0,1,1};
    vt[8]  = '{0,0,0,0, 0,1,1};
    vt[9]  = '{0,0,0,0, 0,1,1};
    vt[10] = '{0,0,0,0, 0,1,1};
    vt[11] = '{0,0,0,0, 0,1,1};
    vt[12] = '{0,0,1,0, 1,1,1};
    vt[13] = '{0,0,0,0, 1,1,1};
    vt[14] = '{0,1,0,0, 1,1,1};
    vt[15] = '{1,0,0,0, 0,0,0};
    vt[16] = '{0,0,0,0, 0,0,0};
    vt[17] = '{0,1,1,0, 0,1,0};
    vt[18] = '{0,0,1,0, 1,1,0};
    vt[19] = '{1,0,0,0, 0,0,0};
    vt[20] = '{0,0,0,0, 0,0,0};

    for (int i = 0; i < 21; i++) begin
      rst        = vt[i].rst;
      start_i    = vt[i].start;
      ram_free_i = vt[i].free;
      rec_val_i  = vt[i].val;
      tick();
      chk($sformatf("vec%0d_rdy_busy_ovf_we", i), {rec_rdy_o, busy_o, ovf_o, we_o},
          {vt[i].exp_rdy, vt[i].exp_busy, vt[i].exp_ovf, 1'b0});
      if (vt[i].rst)
        chk($sformatf("vec%0d_rst_zero", i), {mb_done_o, waddr_o, wdata_o[121:0]}, 128'd0);
    end
    start_i = 1'b0; ram_free_i = 1'b0; rec_val_i = 1'b0;

    // Gap-free macroblock
    clear_log();
    start_mb();
    wait_rdy("plain");
    run_beats(96, 1'b0, -1);
    check_mb("plain");
    chk("plain_ovf", ovf_o, 1'b0);
`ifndef TQ_REC_TRANSPOSE_EN
    chk("plain_addr5_const", log_data[5],
        {{4{8'd23}}, {4{8'd22}}, {4{8'd21}}, {4{8'd20}}});
`endif

    // Random 50% gaps on rec_val_i
    clear_log();
    start_mb();
    wait_rdy("gaps");
    run_beats(96, 1'b1, -1);
    check_mb("gaps");
    chk("gaps_ovf", ovf_o, 1'b0);

    // start_i pulsed on the first beat of block 7
    clear_log();
    start_mb();
    wait_rdy("pulse");
    run_beats(96, 1'b0, 28);
    check_mb("pulse");

    // Reset after 2 blocks and 2 rows
    clear_log();
    start_mb();
    wait_rdy("rstmid");
    for (int i = 0; i < 10; i++) push_beat({4{8'(i)}});
    rec_val_i = 1'b0;
    rst = 1'b1;
    #1;
    chk("rstmid_zero", {we_o, busy_o, rec_rdy_o, mb_done_o, ovf_o, waddr_o, wdata_o[117:0]}, 128'd0);
    tick();
    rst = 1'b0;
    for (int t = 0; t < 5; t++) tick();
    chk("rstmid_nwr", 128'(log_addr.size()), 128'd2);
    clear_log();
    start_mb();
    wait_rdy("after_rst");
    run_beats(96, 1'b0, -1);
    check_mb("after_rst");

    // Distinct-pixel block to check element placement
    clear_log();
    start_mb();
    wait_rdy("place");
    push_beat(32'h03020100);
    push_beat(32'h07060504);
    push_beat(32'h0B0A0908);
    push_beat(32'h0F0E0D0C);
    rec_val_i = 1'b0;
    tick();
    chk("place_nwr", 128'(log_addr.size()), 128'd1);
`ifdef TQ_REC_TRANSPOSE_EN
    chk("place_word", log_data[0], 128'h0F0B07030E0A06020D0905010C080400);
`else
    chk("place_word", log_data[0], 128'h0F0E0D0C0B0A09080706050403020100);
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
